// File: rtl/mem_request_unit.sv
// mem_request_unit
// Serialises instruction fetches and data loads/stores from the core onto a
// single-port memory bus, one transaction at a time. Each request type has a
// one-deep pending slot; data requests take priority over fetches. A bus
// timeout aborts a stalled transaction, sets a sticky error flag and returns
// a safe result (NOP for fetches, zero for loads) so the core never hangs.
//
// Ports:
//   i_clk, i_rst                 clock (rising edge), async active-high reset
//   i_fetch_req, i_pc            fetch request pulse and address
//   i_mem_read, i_mem_write      load / store request pulses (both = store)
//   i_data_addr, i_data_wdata    load/store address and store data
//   i_byte_en                    byte lanes for the data request
//   o_instruction, o_i_ready     last fetched instruction, one-cycle valid pulse
//   o_data_rdata, o_d_ready      last load result, one-cycle completion pulse
//   o_busy                       transaction in flight or request pending
//   o_bus_err                    sticky bus timeout flag
//   o_bus_req/we/addr/wdata/sel  bus request side
//   i_bus_ack, i_bus_rdata       bus completion and read data
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no bus transaction; pick data slot, then fetch
// S_FETCH | instruction read on the bus
// S_DATA  | load or store on the bus
module mem_request_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_fetch_req,
    input  logic [ADDR_W-1:0] i_pc,
    input  logic              i_mem_read,
    input  logic              i_mem_write,
    input  logic [ADDR_W-1:0] i_data_addr,
    input  logic [DATA_W-1:0] i_data_wdata,
    input  logic [3:0]        i_byte_en,
    output logic [DATA_W-1:0] o_instruction,
    output logic              o_i_ready,
    output logic [DATA_W-1:0] o_data_rdata,
    output logic              o_d_ready,
    output logic              o_busy,
    output logic              o_bus_err,
    output logic              o_bus_req,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    output logic [3:0]        o_bus_sel,
    input  logic              i_bus_ack,
    input  logic [DATA_W-1:0] i_bus_rdata
);

    // The counter only has to reach TIMEOUT-1 (see abort condition below).
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [DATA_W-1:0] NOP_INSTR = DATA_W'(32'h0000_0013);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DATA} state_t;

    state_t              r_state;
    state_t              w_next;

    logic                r_f_pend;
    logic [ADDR_W-1:0]   r_f_pc;
    logic                r_d_pend;
    logic                r_d_we;
    logic [ADDR_W-1:0]   r_d_addr;
    logic [DATA_W-1:0]   r_d_wdata;
    logic [3:0]          r_d_sel;

    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_instruction;
    logic [DATA_W-1:0]   r_data_rdata;
    logic                r_i_ready;
    logic                r_d_ready;
    logic                r_bus_err;
    logic                r_bus_we;
    logic [ADDR_W-1:0]   r_bus_addr;
    logic [DATA_W-1:0]   r_bus_wdata;
    logic [3:0]          r_bus_sel;

    logic                w_d_req;
    logic                w_start_f;
    logic                w_start_d;
    logic                w_done;
    logic                w_abort;
    logic                w_timeout;
    logic                w_d_we;
    logic [ADDR_W-1:0]   w_d_addr;
    logic [DATA_W-1:0]   w_d_wdata;
    logic [3:0]          w_d_sel;
    logic [ADDR_W-1:0]   w_f_pc;

    assign w_d_req = i_mem_read | i_mem_write;

    // An occupied slot wins over a request pulse on the same edge.
    assign w_d_we    = r_d_pend ? r_d_we    : i_mem_write;
    assign w_d_addr  = r_d_pend ? r_d_addr  : i_data_addr;
    assign w_d_wdata = r_d_pend ? r_d_wdata : i_data_wdata;
    assign w_d_sel   = r_d_pend ? r_d_sel   : i_byte_en;
    assign w_f_pc    = r_f_pend ? r_f_pc    : i_pc;

    // r_cnt counts completed wait cycles; the edge that would make it reach
    // TIMEOUT is the abort edge, so bus_req is held for exactly TIMEOUT cycles.
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_comb begin
        w_next    = r_state;
        w_start_f = 1'b0;
        w_start_d = 1'b0;
        w_done    = 1'b0;
        w_abort   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_d_pend || w_d_req) begin
                    w_next    = S_DATA;
                    w_start_d = 1'b1;
                end else if (r_f_pend || i_fetch_req) begin
                    w_next    = S_FETCH;
                    w_start_f = 1'b1;
                end
            end
            S_FETCH, S_DATA: begin
                if (i_bus_ack) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end else if (w_timeout) begin
                    w_next  = S_IDLE;
                    w_abort = 1'b1;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_f_pend      <= 1'b0;
            r_f_pc        <= '0;
            r_d_pend      <= 1'b0;
            r_d_we        <= 1'b0;
            r_d_addr      <= '0;
            r_d_wdata     <= '0;
            r_d_sel       <= '0;
            r_cnt         <= '0;
            r_instruction <= '0;
            r_data_rdata  <= '0;
            r_i_ready     <= 1'b0;
            r_d_ready     <= 1'b0;
            r_bus_err     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_bus_sel     <= '0;
        end else begin
            r_i_ready <= 1'b0;
            r_d_ready <= 1'b0;

            if (w_start_f) begin
                r_f_pend <= 1'b0;
            end else if (i_fetch_req && !r_f_pend) begin
                r_f_pend <= 1'b1;
                r_f_pc   <= i_pc;
            end

            if (w_start_d) begin
                r_d_pend <= 1'b0;
            end else if (w_d_req && !r_d_pend) begin
                r_d_pend  <= 1'b1;
                r_d_we    <= i_mem_write;
                r_d_addr  <= i_data_addr;
                r_d_wdata <= i_data_wdata;
                r_d_sel   <= i_byte_en;
            end

            if (w_start_f) begin
                r_bus_we    <= 1'b0;
                r_bus_addr  <= w_f_pc;
                r_bus_wdata <= '0;
                r_bus_sel   <= 4'b1111;
            end else if (w_start_d) begin
                r_bus_we    <= w_d_we;
                r_bus_addr  <= w_d_addr;
                r_bus_wdata <= w_d_we ? w_d_wdata : '0;
                r_bus_sel   <= w_d_sel;
            end

            if (r_state != S_IDLE && w_next != S_IDLE) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end

            if (w_done || w_abort) begin
                if (r_state == S_FETCH) begin
                    r_i_ready     <= 1'b1;
                    r_instruction <= w_done ? i_bus_rdata : NOP_INSTR;
                end else begin
                    r_d_ready <= 1'b1;
                    if (!r_bus_we) begin
                        r_data_rdata <= w_done ? i_bus_rdata : '0;
                    end
                end
            end

            if (w_abort) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    assign o_bus_req     = (r_state != S_IDLE);
    assign o_busy        = o_bus_req | r_f_pend | r_d_pend;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;
    assign o_bus_sel     = r_bus_sel;
    assign o_instruction = r_instruction;
    assign o_data_rdata  = r_data_rdata;
    assign o_i_ready     = r_i_ready;
    assign o_d_ready     = r_d_ready;
    assign o_bus_err     = r_bus_err;

endmodule

// File: tb/tb_mem_request_unit.sv
module tb_mem_request_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_req, mem_read, mem_write, bus_ack;
    logic [31:0] pc, data_addr, data_wdata, bus_rdata;
    logic [3:0]  byte_en;
    logic [31:0] instruction, data_rdata, bus_addr, bus_wdata;
    logic        i_ready, d_ready, busy, bus_err, bus_req, bus_we;
    logic [3:0]  bus_sel;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_request_unit #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_fetch_req(fetch_req), .i_pc(pc),
        .i_mem_read(mem_read), .i_mem_write(mem_write),
        .i_data_addr(data_addr), .i_data_wdata(data_wdata), .i_byte_en(byte_en),
        .o_instruction(instruction), .o_i_ready(i_ready),
        .o_data_rdata(data_rdata), .o_d_ready(d_ready),
        .o_busy(busy), .o_bus_err(bus_err),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .o_bus_sel(bus_sel),
        .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
    );

    typedef struct {
        logic        fr, mr, mw;
        logic [31:0] pc, addr, wd;
        logic [3:0]  be;
        logic        ack;
        logic [31:0] rd;
        logic        e_req, e_we;
        logic [31:0] e_addr;
        logic [3:0]  e_sel;
        logic [31:0] e_wd;
        logic        e_ir, e_dr;
        logic [31:0] e_inst, e_dat;
        logic        e_busy, e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic fr, input logic mr, input logic mw,
        input logic [31:0] p, input logic [31:0] a, input logic [31:0] w,
        input logic [3:0] be, input logic ack, input logic [31:0] rd,
        input logic e_req, input logic e_we, input logic [31:0] e_addr,
        input logic [3:0] e_sel, input logic [31:0] e_wd,
        input logic e_ir, input logic e_dr, input logic [31:0] e_inst,
        input logic [31:0] e_dat, input logic e_busy, input logic e_err);
        vec_t t;
        t.fr = fr; t.mr = mr; t.mw = mw; t.pc = p; t.addr = a; t.wd = w;
        t.be = be; t.ack = ack; t.rd = rd;
        t.e_req = e_req; t.e_we = e_we; t.e_addr = e_addr; t.e_sel = e_sel;
        t.e_wd = e_wd; t.e_ir = e_ir; t.e_dr = e_dr; t.e_inst = e_inst;
        t.e_dat = e_dat; t.e_busy = e_busy; t.e_err = e_err;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        fetch_req = 0; mem_read = 0; mem_write = 0; bus_ack = 0;
        pc = 0; data_addr = 0; data_wdata = 0; byte_en = 0; bus_rdata = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".bus_req"}, 64'(bus_req), 64'd0);
        check({tag, ".busy"}, 64'(busy), 64'd0);
        check({tag, ".instr"}, 64'(instruction), 64'd0);
        check({tag, ".rdata"}, 64'(data_rdata), 64'd0);
        check({tag, ".err"}, 64'(bus_err), 64'd0);
        check({tag, ".rdy"}, 64'({i_ready, d_ready}), 64'd0);
        check({tag, ".bus"}, 64'({bus_we, bus_sel, bus_addr}), 64'd0);
    endtask

    initial begin
        int hi;
        bit seen;
        int n_fetch;

        // Stimulus row: inputs before an edge, expected outputs just after it.
        // Test 1: zero-wait fetch
        vecs.push_back(mk(1,0,0, 32'h0,0,0, 4'h0, 0,0,  1,0,32'h0,4'hF,0, 0,0,32'h0,32'h0, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 1,32'h3E80_0093,  0,0,0,0,0, 1,0,32'h3E80_0093,32'h0, 0,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 0,0,  0,0,0,0,0, 0,0,32'h3E80_0093,32'h0, 0,0));
        // Test 2: store, then load with 3 wait cycles (ack lands on the timeout edge)
        vecs.push_back(mk(0,0,1, 0,32'h100,32'hDEAD_BEEF, 4'hF, 0,0,  1,1,32'h100,4'hF,32'hDEAD_BEEF, 0,0,32'h3E80_0093,32'h0, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 1,32'h1234_5678,  0,0,0,0,0, 0,1,32'h3E80_0093,32'h0, 0,0));
        vecs.push_back(mk(0,1,0, 0,32'h100,0, 4'hF, 0,0,  1,0,32'h100,4'hF,32'h0, 0,0,32'h3E80_0093,32'h0, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 0,0,  1,0,32'h100,4'hF,32'h0, 0,0,32'h3E80_0093,32'h0, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 0,0,  1,0,32'h100,4'hF,32'h0, 0,0,32'h3E80_0093,32'h0, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 0,0,  1,0,32'h100,4'hF,32'h0, 0,0,32'h3E80_0093,32'h0, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 1,32'hDEAD_BEEF,  0,0,0,0,0, 0,1,32'h3E80_0093,32'hDEAD_BEEF, 0,0));
        // Test 3: simultaneous fetch + load, data first
        vecs.push_back(mk(1,1,0, 32'h200,32'h104,0, 4'h3, 0,0,  1,0,32'h104,4'h3,32'h0, 0,0,32'h3E80_0093,32'hDEAD_BEEF, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 1,32'hCAFE_F00D,  0,0,0,0,0, 0,1,32'h3E80_0093,32'hCAFE_F00D, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 0,0,  1,0,32'h200,4'hF,32'h0, 0,0,32'h3E80_0093,32'hCAFE_F00D, 1,0));
        vecs.push_back(mk(0,0,0, 0,0,0, 4'h0, 1,32'h0000_0513,  0,0,0,0,0, 1,0,32'h0000_0513,32'hCAFE_F00D, 0,0));

        idle_inputs();
        rst = 1;
        #12;
        check_all_zero("reset");
        step();
        rst = 0;
        step();

        foreach (vecs[i]) begin
            fetch_req = vecs[i].fr; mem_read = vecs[i].mr; mem_write = vecs[i].mw;
            pc = vecs[i].pc; data_addr = vecs[i].addr; data_wdata = vecs[i].wd;
            byte_en = vecs[i].be; bus_ack = vecs[i].ack; bus_rdata = vecs[i].rd;
            step();
            check($sformatf("v%0d.bus_req", i), 64'(bus_req), 64'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                check($sformatf("v%0d.bus_we", i), 64'(bus_we), 64'(vecs[i].e_we));
                check($sformatf("v%0d.bus_addr", i), 64'(bus_addr), 64'(vecs[i].e_addr));
                check($sformatf("v%0d.bus_sel", i), 64'(bus_sel), 64'(vecs[i].e_sel));
                check($sformatf("v%0d.bus_wdata", i), 64'(bus_wdata), 64'(vecs[i].e_wd));
            end
            check($sformatf("v%0d.i_ready", i), 64'(i_ready), 64'(vecs[i].e_ir));
            check($sformatf("v%0d.d_ready", i), 64'(d_ready), 64'(vecs[i].e_dr));
            check($sformatf("v%0d.instr", i), 64'(instruction), 64'(vecs[i].e_inst));
            check($sformatf("v%0d.rdata", i), 64'(data_rdata), 64'(vecs[i].e_dat));
            check($sformatf("v%0d.busy", i), 64'(busy), 64'(vecs[i].e_busy));
            check($sformatf("v%0d.bus_err", i), 64'(bus_err), 64'(vecs[i].e_err));
        end
        idle_inputs();
        step();

        // Test 4: fetch timeout, bus_req held exactly TIMEOUT=4 cycles
        fetch_req = 1; pc = 32'h300;
        step();
        fetch_req = 0; pc = 0;
        hi = bus_req ? 1 : 0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (i_ready) begin seen = 1; break; end
            if (bus_req) hi++;
        end
        check("to.seen_ready", 64'(seen), 64'd1);
        check("to.req_cycles", 64'(hi), 64'd4);
        check("to.instr_nop", 64'(instruction), 64'h13);
        check("to.bus_err", 64'(bus_err), 64'd1);
        check("to.bus_req_low", 64'(bus_req), 64'd0);

        // Successful fetch after the timeout; error stays set
        step();
        fetch_req = 1; pc = 32'h304;
        step();
        fetch_req = 0; pc = 0;
        bus_ack = 1; bus_rdata = 32'h0010_0073;
        step();
        bus_ack = 0; bus_rdata = 0;
        check("to2.i_ready", 64'(i_ready), 64'd1);
        check("to2.instr", 64'(instruction), 64'h0010_0073);
        check("to2.bus_err_sticky", 64'(bus_err), 64'd1);

        // Timed-out load returns zero
        step();
        mem_read = 1; data_addr = 32'h108; byte_en = 4'hF;
        step();
        mem_read = 0; data_addr = 0; byte_en = 0;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (d_ready) begin seen = 1; break; end
        end
        check("tol.seen_ready", 64'(seen), 64'd1);
        check("tol.rdata_zero", 64'(data_rdata), 64'd0);

        // Test 6: second fetch_req while slot pending is dropped
        step();
        mem_write = 1; data_addr = 32'h140; data_wdata = 32'h55; byte_en = 4'h1;
        step();
        mem_write = 0; data_addr = 0; data_wdata = 0; byte_en = 0;
        fetch_req = 1; pc = 32'h400;
        step();
        pc = 32'h500;
        step();
        fetch_req = 0; pc = 0;
        check("drop.in_data", 64'({bus_req, bus_we}), 64'b11);
        bus_ack = 1;
        step();
        bus_ack = 0;
        check("drop.d_ready", 64'(d_ready), 64'd1);
        step();
        check("drop.fetch_addr", 64'({bus_req, bus_addr}), {31'd0, 1'b1, 32'h400});
        bus_ack = 1; bus_rdata = 32'h0000_0033;
        step();
        bus_ack = 0; bus_rdata = 0;
        check("drop.instr", 64'({i_ready, instruction}), {31'd0, 1'b1, 32'h33});
        n_fetch = 0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus_req) n_fetch++;
        end
        check("drop.no_second_fetch", 64'(n_fetch), 64'd0);
        check("drop.not_busy", 64'(busy), 64'd0);

        // Test 5: reset mid-transaction, then late ack is ignored
        mem_write = 1; data_addr = 32'h600; data_wdata = 32'hA5A5_A5A5; byte_en = 4'hF;
        step();
        mem_write = 0; data_addr = 0; data_wdata = 0; byte_en = 0;
        check("rst.pre_req", 64'(bus_req), 64'd1);
        #1;
        rst = 1;
        #1;
        check_all_zero("rst.async");
        step();
        rst = 0;
        bus_ack = 1; bus_rdata = 32'h7777_7777;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (i_ready || d_ready || bus_req) seen = 1;
        end
        bus_ack = 0; bus_rdata = 0;
        check("rst.late_ack_ignored", 64'(seen), 64'd0);
        check("rst.rdata_still0", 64'(data_rdata), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
